// File: rtl/aes_subbytes.sv
// AES forward SubBytes stage: sixteen parallel S-box lookups with a registered
// 128-bit output and matching valid strobe (one-cycle latency).
module aes_subbytes (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [127:0] state_in,
   output logic         out_valid,
   output logic [127:0] state_out
);

   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned NUM_BYTES = 16;

   // Forward S-box as a full 256-entry constant table; every input is covered.
   function automatic logic [BYTE_W-1:0] sbox(input logic [BYTE_W-1:0] b);
      logic [BYTE_W-1:0] s;
      s = 8'h00;
      case (b)
         8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
         8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
         8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
         8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
         8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
         8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
         8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
         8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
         8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
         8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
         8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
         8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
         8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
         8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
         8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
         8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
         8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
         8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
         8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
         8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
         8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
         8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
         8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
         8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
         8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
         8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
         8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
         8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
         8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
         8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
         8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
         8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      endcase
      return s;
   endfunction

   logic [127:0] sub_state;

   // Sixteen independent lanes; byte ordering is preserved across the stage.
   always_comb begin
      sub_state = '0;
      for (int i = 0; i < int'(NUM_BYTES); i++) begin
         sub_state[i*BYTE_W +: BYTE_W] = sbox(state_in[i*BYTE_W +: BYTE_W]);
      end
   end

   // Output register; state_out holds its value while no new state arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         state_out <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            state_out <= sub_state;
         end
      end
   end

endmodule

// File: tb/tb_aes_subbytes.sv
// Bench for aes_subbytes: the reference S-box is built arithmetically (GF(2^8)
// inverse plus affine map) and compared with the DUT over fixed and random states.
module tb_aes_subbytes;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [127:0] state_in;
   logic         out_valid;
   logic [127:0] state_out;

   int unsigned passed = 0;
   int unsigned total  = 0;
   logic [7:0]  ref_sbox [256];

   always #5 clk = ~clk;

   aes_subbytes dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .state_in  (state_in),
      .out_valid (out_valid),
      .state_out (state_out)
   );

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      for (int k = 0; k < 8; k++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // Inverse as a^254 (0 maps to 0 naturally), then the affine transform.
   function automatic logic [7:0] model_byte(input logic [7:0] a);
      logic [7:0] inv;
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gf_mul(inv, a);
      if (a == 8'h00) inv = 8'h00;
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] model_state(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int j = 0; j < 16; j++) r[127-8*j -: 8] = ref_sbox[s[127-8*j -: 8]];
      return r;
   endfunction

   task automatic apply_and_check(input string name, input logic [127:0] s, input logic [127:0] want);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b1;
      state_in = s;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || state_out !== want)
         $display("FAIL %s: got v=%b %h, want v=1 %h", name, out_valid, state_out, want);
      else passed++;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      state_in = 128'h0123456789abcdef0123456789abcdef;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         total++;
         if (out_valid !== 1'b0 || state_out !== 128'h0)
            $display("FAIL reset[%0d]: got v=%b %h, want v=0 0", c, out_valid, state_out);
         else passed++;
      end
   endtask

   task automatic test_pattern();
      logic [127:0] want;
      want = 128'h63637c7c7b7bc5c57676c0c07575d2d2;
      apply_and_check("pattern", 128'h00000101030307070f0f1f1f3f3f7f7f, want);
      @(negedge clk);
      in_valid = 1'b0;
      state_in = 128'hffffffffffffffffffffffffffffffff;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || state_out !== want)
         $display("FAIL pattern_hold: got v=%b %h, want v=0 %h", out_valid, state_out, want);
      else passed++;
   endtask

   task automatic test_fips_vector();
      apply_and_check("fips_round1", 128'h193de3bea0f4e22b9ac68d2ae9f84808,
                      128'hd42711aee0bf98f1b8b45de51e415230);
   endtask

   task automatic test_extremes();
      apply_and_check("all_zero", {16{8'h00}}, {16{8'h63}});
      apply_and_check("all_ones", {16{8'hff}}, {16{8'h16}});
      apply_and_check("all_53",   {16{8'h53}}, {16{8'hed}});
   endtask

   task automatic test_random();
      logic [127:0] s;
      for (int n = 0; n < 16; n++) begin
         s = {$urandom, $urandom, $urandom, $urandom};
         apply_and_check("random", s, model_state(s));
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]   base;
      logic [127:0] s;
      logic [127:0] want;
      base = 8'($urandom);
      for (int i = 0; i < 256; i++) begin
         for (int j = 0; j < 16; j++) s[127-8*j -: 8] = 8'(i + j*17 + int'(base));
         @(negedge clk);
         rst      = 1'b0;
         in_valid = 1'b1;
         state_in = s;
         want     = model_state(s);
         @(posedge clk); #1;
         total++;
         if (out_valid !== 1'b1 || state_out !== want)
            $display("FAIL stream[%0d]: got v=%b %h, want v=1 %h", i, out_valid, state_out, want);
         else passed++;
      end
   endtask

   task automatic test_reset_midstream();
      logic [127:0] s;
      for (int i = 0; i < 4; i++) begin
         s = {$urandom, $urandom, $urandom, $urandom};
         apply_and_check("pre_reset", s, model_state(s));
      end
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      state_in = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || state_out !== 128'h0)
         $display("FAIL mid_reset: got v=%b %h, want v=0 0", out_valid, state_out);
      else passed++;
      s = {$urandom, $urandom, $urandom, $urandom};
      apply_and_check("post_reset", s, model_state(s));
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      state_in = '0;
      for (int v = 0; v < 256; v++) ref_sbox[v] = model_byte(8'(v));
      test_reset();
      test_pattern();
      test_fips_vector();
      test_extremes();
      test_random();
      test_back_to_back();
      test_reset_midstream();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/aes_subbytes.md
Name: aes_subbytes

Overview:
- AES SubBytes stage (FIPS-197 §5.1.1) for the 128-bit AES datapath.
- Each of the 16 state bytes is replaced independently by its forward AES S-box value.
- The output is registered, giving one-cycle latency with a valid strobe, so the block drops into the pipelined round datapath between AddRoundKey and ShiftRows.
- Inverse S-box is out of scope.

Parameters:
- None. Widths are fixed by AES.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  state_in carries a valid state this cycle.
- state_in  input  128  input state; byte i = state_in[127-8i -: 8], i=0..15, so byte 0 is bits [127:120].
- out_valid  output  1  state_out holds a fresh result.
- state_out  output  128  substituted state; same byte ordering as state_in.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - On a rising clk edge with rst=1: out_valid<=0 and state_out<=128'h0.
  - rst has priority over in_valid.
- Substitution:
  - state_out byte i = SBOX(state_in byte i) for all 16 bytes in parallel.
  - No mixing between bytes.
  - No dependence on byte position or on previous data.
- SBOX:
  - Standard AES forward S-box: multiplicative inverse in GF(2^8) modulo x^8+x^4+x^3+x+1, with 00 mapped to 00, followed by the affine transform with constant 0x63.
  - Implemented as a 256-entry constant case lookup in a shared function or submodule, instantiated 16 times.
  - Required anchor values: 00->63, 01->7c, 03->7b, 07->c5, 0f->76, 1f->c0, 3f->75, 7f->d2, 53->ed, ff->16.
- Timing:
  - When rst=0 and in_valid=1 at edge k: state_out<=SBOX(state_in) and out_valid<=1, both visible after edge k. Latency is exactly 1 cycle.
  - When rst=0 and in_valid=0: out_valid<=0 and state_out holds its previous value.
- Throughput: one state per cycle. Back-to-back in_valid produces back-to-back out_valid with no bubbles.
- No backpressure: downstream must accept a result whenever out_valid=1.
- Reset mid-stream: a result in flight is discarded; the cycle after reset shows out_valid=0 and state_out=0.
- X-free: every 8-bit input value maps to a defined output. The lookup has no default-X branch.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 and a nonzero state_in -> out_valid=0, state_out=128'h0.
- Pattern vector: state_in=128'h00000101030307070f0f1f1f3f3f7f7f, in_valid=1 for one cycle -> next cycle state_out=128'h63637c7c7b7bc5c57676c0c07575d2d2, out_valid=1; the following cycle out_valid=0 with state_out held.
- FIPS-197 Appendix B round-1 input: state_in=128'h193de3bea0f4e22b9ac68d2ae9f84808 -> state_out=128'hd42711aee0bf98f1b8b45de51e415230.
- Extremes: all-zero input -> 128'h6363…63; all-ones input -> 128'h1616…16; state_in=128'h53 repeated in all bytes -> 128'hed repeated.
- Streaming: 256 consecutive cycles with in_valid=1, every byte lane sweeping 00..ff at a different offset -> each output byte matches a software S-box model one cycle later, with no gaps in out_valid.
- Reset mid-stream: assert rst during streaming -> next cycle out_valid=0 and state_out=0; first valid input after rst deasserts yields a correct result one cycle later.
